cv_uart_tx: RTL
===============

Name: cv_uart_tx

Overview:
UART serializer on the transmit side of the serial hex calculator; it is the far end of the calculator FSM's TX_RDY_T / TX_DATA_T / TX_RDY_R handshake.
- Accepts bytes while TX_RDY_T is held high.
- Shifts each byte out on TXD as an 8N1 frame (optionally 8E1/8O1).
- Pulses TX_RDY_R once per completed frame so the FSM can present the next byte.
- Frame format matches the calculator's UART receiver, whose RX_DATA_R[9:8] error flags cover parity and framing.

Parameters:
- CLKS_PER_BIT, 868: CLK cycles per bit period (100 MHz / 115200). Legal range >= 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when the parity feature is compiled in.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: reset. Asynchronous, active-high.
- TX_RDY_T, in, 1: a byte is available on TX_DATA_T. Held high for a whole message.
- TX_DATA_T, in, 8: byte to send. Sampled only in IDLE.
- TX_RDY_R, out, 1: one-cycle pulse at the end of each frame. Means "byte sent, present the next one".
- TXD, out, 1: serial line output. Idles high (mark).
- TX_BUSY, out, 1: high from frame start through the last stop-bit cycle.

Behaviour:
- Reset (any time, including mid-frame), asynchronous:
  - TXD=1, TX_RDY_R=0, TX_BUSY=0.
  - State=IDLE; bit counter, baud counter and shift register all 0.
  - A partially sent frame is abandoned; the line returns to mark immediately.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, START, DATA, PAR (parity feature only), STOP.
- IDLE:
  - TXD=1, TX_BUSY=0.
  - At a rising edge with TX_RDY_T=1: latch TX_DATA_T into the shift register, clear the baud counter, go to START, set TX_BUSY=1, drive TXD=0.
- START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - Shift right once per bit; a 3-bit counter tracks bit index 0..7.
  - After bit 7, go to PAR if compiled in, otherwise STOP.
- STOP:
  - TXD=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - TX_RDY_R=1 in exactly the final cycle of the last stop bit; TX_BUSY falls at the same edge that enters IDLE.
- Handshake timing:
  - After the TX_RDY_R pulse, the block spends at least one cycle in IDLE before sampling TX_RDY_T again.
  - That cycle gives the FSM time to update TX_DATA_T, or to drop TX_RDY_T after the final LF.
  - Back-to-back frames are therefore separated by exactly 1 CLK of mark.
- Changes on TX_DATA_T while a frame is in progress are ignored.
- If TX_RDY_T drops mid-frame, the frame still completes and TX_RDY_R still pulses.
- TX_RDY_R never pulses without a frame having been started.
- Frame length in CLK cycles: (10 + P + STOP_BITS - 1) * CLKS_PER_BIT, where P=1 with parity and 0 without.
- Baud counter: width $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1, where the bit or state advance happens.

Optional Feature:
- Macro: CV_UART_TX_PARITY_EN.
- Defined:
  - PAR state inserted between bit 7 and STOP, lasting CLKS_PER_BIT cycles.
  - TXD = ^data XOR PARITY_ODD, computed from the latched byte.
- Undefined:
  - No PAR state and no parity logic; 8N1 framing.
  - PARITY_ODD is ignored.
- Must match the receiver's build, or RX_DATA_R parity flags will fire.

Decomposition:
- Shared package/include cv_uart_pkg:
  - TX state encoding constants (IDLE/START/DATA/PAR/STOP).
  - Default CLKS_PER_BIT.
  - Parity-type constants PAR_EVEN/PAR_ODD, shared with the receiver.
- One sub-module, cv_baud_tick:
  - Synchronous-clear counter producing a one-cycle tick every CLKS_PER_BIT cycles.
  - Cleared by the TX FSM at frame start.

Test Plan:
1. CLKS_PER_BIT=4, no parity; TX_RDY_T=1 with TX_DATA_T=0x41, then drop TX_RDY_T on the TX_RDY_R pulse.
   - TXD = 0,1,0,0,0,0,0,1,0,1 (start, LSB-first data, stop), 4 cycles each.
   - Exactly one TX_RDY_R pulse at cycle 40 after acceptance; TXD stays 1 afterwards.
2. Message "3A\r\n": FSM model updates TX_DATA_T one cycle after each TX_RDY_R.
   - Four frames decode to 0x33, 0x41, 0x0D, 0x0A with a 1-cycle mark gap between frames.
   - Exactly 4 TX_RDY_R pulses.
3. Change TX_DATA_T from 0x55 to 0xFF mid-frame.
   - Serialized byte is still 0x55.
4. Assert RST during data bit 3 of 0x0F.
   - TXD=1, TX_BUSY=0, TX_RDY_R=0 immediately.
   - No TX_RDY_R pulse afterwards; a new send after release transmits correctly.
5. CV_UART_TX_PARITY_EN defined, PARITY_ODD=0, byte 0x07: parity bit = 1. With PARITY_ODD=1: parity bit = 0. Frame length 44 cycles at CLKS_PER_BIT=4.
6. STOP_BITS=2, byte 0x00: stop phase lasts 8 cycles; TX_RDY_R is asserted only in the 8th stop cycle.

Source files
------------

// File: rtl/cv_uart_pkg.sv
// Shared UART constants: TX state encoding, default bit period, parity selectors.
package cv_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_e;

  localparam int unsigned DEF_CLKS_PER_BIT = 868;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/cv_baud_tick.sv
// Bit-period counter: tick in the last cycle of every CLKS_PER_BIT-cycle period,
// pre_tick one cycle earlier. clr restarts the period synchronously.
module cv_baud_tick
  import cv_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick     = (cnt_q == CNT_LAST);
  assign pre_tick = (cnt_q == CNT_PRE);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cv_uart_tx.sv
// UART transmitter, 8N1 by default; define CV_UART_TX_PARITY_EN for 8E1/8O1.
// TX_RDY_R pulses in the final stop-bit cycle; one IDLE cycle separates frames.
module cv_uart_tx
  import cv_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_RDY_T,
  input  logic [7:0] TX_DATA_T,
  output logic       TX_RDY_R,
  output logic       TXD,
  output logic       TX_BUSY
);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_param
    $error("cv_uart_tx: illegal parameter value");
  end

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       rdy_q, rdy_d;
  logic       baud_clr, baud_tick, baud_pre;
`ifdef CV_UART_TX_PARITY_EN
  localparam logic PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  logic       par_q, par_d;
`endif

  assign baud_clr = (state_q == TX_IDLE) && TX_RDY_T;

  cv_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (baud_clr),
    .tick     (baud_tick),
    .pre_tick (baud_pre)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
`ifdef CV_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
`ifdef CV_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // bit_idx_q counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef CV_UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (TX_RDY_T) begin
          state_d   = TX_START;
          shift_d   = TX_DATA_T;
          bit_idx_d = '0;
`ifdef CV_UART_TX_PARITY_EN
          par_d     = (^TX_DATA_T) ^ PAR_SEL;
`endif
        end
      end
      TX_START: if (baud_tick) state_d = TX_DATA;
      TX_DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef CV_UART_TX_PARITY_EN
            state_d   = TX_PAR;
`else
            state_d   = TX_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef CV_UART_TX_PARITY_EN
      TX_PAR: if (baud_tick) state_d = TX_STOP;
`endif
      TX_STOP: begin
        if (baud_tick) begin
          if (bit_idx_q == STOP_LAST) state_d = TX_IDLE;
          else                        bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next-cycle values;
  // TX_RDY_R is armed one cycle ahead via pre_tick.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != TX_IDLE);
    rdy_d  = (state_q == TX_STOP) && (bit_idx_q == STOP_LAST) && baud_pre;
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
`ifdef CV_UART_TX_PARITY_EN
      TX_PAR:   txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  assign TXD      = txd_q;
  assign TX_BUSY  = busy_q;
  assign TX_RDY_R = rdy_q;

endmodule
